// File: rtl/regbank_wr_resp_pkg.sv
// Shared core constants for the write-back responder: state encoding,
// core data/address widths and the FSM select-line encodings.
package regbank_wr_resp_pkg;

  localparam int CORE_DATA_W = 4;
  localparam int CORE_ADDR_W = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } wr_state_t;

  localparam logic SEL_RD  = 1'b1;
  localparam logic SEL_R0  = 1'b0;
  localparam logic SEL_IMM = 1'b1;
  localparam logic SEL_ULA = 1'b0;

endpackage

// File: rtl/regbank_storage.sv
// General-purpose register array: one synchronous write port, two
// combinational read ports. Out-of-range addresses never write and read as 0.
module regbank_storage
  import regbank_wr_resp_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W,
  parameter int NREGS  = 4,
  parameter int ADDR_W = CORE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];

  // Address decode per register, so an index past NREGS matches nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NREGS; i++)
        if (waddr == ADDR_W'(i)) mem[i] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (raddr_a == ADDR_W'(i)) rdata_a = mem[i];
      if (raddr_b == ADDR_W'(i)) rdata_b = mem[i];
    end
  end

endmodule

// File: rtl/regbank_wr_resp.sv
// Write-back responder: captures a level-held write request, commits it after
// WR_LAT cycles of modelled storage latency and returns a one-cycle wr_ack.
module regbank_wr_resp
  import regbank_wr_resp_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W,
  parameter int NREGS  = 4,
  parameter int ADDR_W = CORE_ADDR_W,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena_wr,
  input  logic              sel_r0_rd,
  input  logic              sel_ldr_ula,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] ula_in,
  output logic              wr_ack,
  output logic              busy,
  output logic [DATA_W-1:0] r0_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(WR_LAT - 1);

  wr_state_t         state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [ADDR_W-1:0] hold_addr, sel_addr, waddr;
  logic [DATA_W-1:0] hold_data, sel_data, wdata;
  logic              accept, we;

  assign sel_addr = (sel_r0_rd == SEL_RD) ? rd_addr : '0;
  assign sel_data = (sel_ldr_ula == SEL_IMM) ? imm_in : ula_in;
  assign accept   = (state == IDLE) && ena_wr;
  assign busy     = (state != IDLE);

  // With WR_LAT = 1 the commit shares the accepting edge, so it must take the
  // live select/data instead of the not-yet-loaded holding registers.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    we         = 1'b0;
    waddr      = hold_addr;
    wdata      = hold_data;
    case (state)
      IDLE: begin
        if (ena_wr) begin
          if (WR_LAT == 1) begin
            state_next = ACK;
            we         = 1'b1;
            waddr      = sel_addr;
            wdata      = sel_data;
          end else begin
            state_next = BUSY;
            cnt_next   = LAT_LOAD;
          end
        end
      end
      BUSY: begin
        cnt_next = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          we         = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = RELEASE;
      RELEASE: if (!ena_wr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_ack    <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      wr_ack <= (state_next == ACK);
      if (accept) begin
        hold_addr <= sel_addr;
        hold_data <= sel_data;
      end
    end
  end

  regbank_storage #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a ('0),
    .raddr_b (rd_addr),
    .rdata_a (r0_data),
    .rdata_b (rd_data)
  );

endmodule

// File: tb/tb_regbank_wr_resp.sv
// Bench for regbank_wr_resp: three instances (WR_LAT 1, 3, 4) share one
// stimulus stream and are checked every cycle against a timestamp-based model.
module tb_regbank_wr_resp;

  logic       clk;
  logic       rst;
  logic       ena_wr;
  logic       sel_r0_rd;
  logic       sel_ldr_ula;
  logic [1:0] rd_addr;
  logic [3:0] imm_in;
  logic [3:0] ula_in;

  logic [2:0] ack;
  logic [2:0] busy;
  logic [3:0] r0_o [3];
  logic [3:0] rd_o [3];

  int nCmp;
  int nFail;
  int cyc;

  // Reference model: a request accepted at edge t commits at edge t+WR_LAT-1;
  // the responder may return to idle from edge commit+2 once ena_wr is low.
  logic [3:0] mreg [3][4];
  bit         pend [3];
  bit         hold [3];
  bit         ack_exp [3];
  int         due [3];
  int         rel_from [3];
  logic [1:0] mtgt [3];
  logic [3:0] mdat [3];

  regbank_wr_resp #(.DATA_W(4), .NREGS(4), .ADDR_W(2), .WR_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst), .ena_wr(ena_wr), .sel_r0_rd(sel_r0_rd),
    .sel_ldr_ula(sel_ldr_ula), .rd_addr(rd_addr), .imm_in(imm_in),
    .ula_in(ula_in), .wr_ack(ack[0]), .busy(busy[0]),
    .r0_data(r0_o[0]), .rd_data(rd_o[0]));

  regbank_wr_resp #(.DATA_W(4), .NREGS(4), .ADDR_W(2), .WR_LAT(3)) dut_lat3 (
    .clk(clk), .rst(rst), .ena_wr(ena_wr), .sel_r0_rd(sel_r0_rd),
    .sel_ldr_ula(sel_ldr_ula), .rd_addr(rd_addr), .imm_in(imm_in),
    .ula_in(ula_in), .wr_ack(ack[1]), .busy(busy[1]),
    .r0_data(r0_o[1]), .rd_data(rd_o[1]));

  regbank_wr_resp #(.DATA_W(4), .NREGS(4), .ADDR_W(2), .WR_LAT(4)) dut_lat4 (
    .clk(clk), .rst(rst), .ena_wr(ena_wr), .sel_r0_rd(sel_r0_rd),
    .sel_ldr_ula(sel_ldr_ula), .rd_addr(rd_addr), .imm_in(imm_in),
    .ula_in(ula_in), .wr_ack(ack[2]), .busy(busy[2]),
    .r0_data(r0_o[2]), .rd_data(rd_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  task automatic compare(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 4; r++) mreg[i][r] = 4'h0;
      pend[i] = 0; hold[i] = 0; ack_exp[i] = 0;
    end
  endtask

  task automatic modelCommit(input int i);
    mreg[i][mtgt[i]] = mdat[i];
    ack_exp[i]  = 1;
    pend[i]     = 0;
    hold[i]     = 1;
    rel_from[i] = cyc + 2;
  endtask

  task automatic modelEdge();
    cyc++;
    for (int i = 0; i < 3; i++) begin
      ack_exp[i] = 0;
      if (pend[i]) begin
        if (cyc == due[i]) modelCommit(i);
      end else if (hold[i]) begin
        if (cyc >= rel_from[i] && !ena_wr) hold[i] = 0;
      end else if (ena_wr) begin
        mtgt[i] = sel_r0_rd ? rd_addr : 2'd0;
        mdat[i] = sel_ldr_ula ? imm_in : ula_in;
        due[i]  = cyc + lat(i) - 1;
        if (lat(i) == 1) modelCommit(i);
        else pend[i] = 1;
      end
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 3; i++) begin
      compare($sformatf("lat%0d.wr_ack@%0d", lat(i), cyc), 4'(ack[i]), 4'(ack_exp[i]));
      compare($sformatf("lat%0d.busy@%0d", lat(i), cyc), 4'(busy[i]), 4'(pend[i] || hold[i]));
      compare($sformatf("lat%0d.r0_data@%0d", lat(i), cyc), r0_o[i], mreg[i][0]);
      compare($sformatf("lat%0d.rd_data[%0d]@%0d", lat(i), rd_addr, cyc), rd_o[i], mreg[i][rd_addr]);
    end
  endtask

  task automatic applyStimulus(input bit e, input bit s_rd, input bit s_imm,
                               input logic [1:0] a, input logic [3:0] im,
                               input logic [3:0] ul);
    @(negedge clk);
    ena_wr = e; sel_r0_rd = s_rd; sel_ldr_ula = s_imm;
    rd_addr = a; imm_in = im; ula_in = ul;
    @(posedge clk);
    if (rst) modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    ena_wr = 1'b0;
    modelClear();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idleSweep();
    for (int a = 0; a < 4; a++) applyStimulus(0, 0, 0, 2'(a), 4'h0, 4'h0);
  endtask

  initial begin
    int ackSeen;
    int hi;
    int lo;
    nCmp = 0; nFail = 0; cyc = 0;
    rst = 1'b1; ena_wr = 0; sel_r0_rd = 0; sel_ldr_ula = 0;
    rd_addr = 0; imm_in = 0; ula_in = 0;
    modelClear();
    doReset();

    $display("[TB] LDR to R2, then hold ena_wr well past every ack");
    applyStimulus(1, 1, 1, 2'd2, 4'hA, 4'h6);
    compare("d1.lat1_ack_on_accept", 4'(ack[0]), 4'h1);
    compare("d1.lat1_rd2", rd_o[0], 4'hA);
    compare("d1.lat3_no_ack_yet", 4'(ack[1]), 4'h0);
    ackSeen = 1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 1, 2'd2, 4'hA, 4'h6);
      ackSeen += int'(ack[0]);
    end
    compare("d1.lat1_single_ack", 4'(ackSeen), 4'h1);
    compare("d1.lat1_busy_in_release", 4'(busy[0]), 4'h1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 2'd2, 4'hA, 4'h6);
    idleSweep();

    $display("[TB] ULA write to R0, source changes after accept");
    applyStimulus(1, 0, 0, 2'd3, 4'h1, 4'h5);
    for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 2'd3, 4'h1, 4'hF);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 2'd0, 4'h1, 4'hF);
    compare("d2.lat3_r0_captured", r0_o[1], 4'h5);
    compare("d2.lat4_r0_captured", r0_o[2], 4'h5);

    $display("[TB] LDR then WB_Rd to R1 with one idle cycle between");
    for (int k = 0; k < 6; k++) applyStimulus(1, 1, 1, 2'd1, 4'h3, 4'h0);
    applyStimulus(0, 1, 1, 2'd1, 4'h3, 4'h0);
    for (int k = 0; k < 6; k++) applyStimulus(1, 1, 0, 2'd1, 4'h0, 4'h9);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 2'd1, 4'h0, 4'h9);
    for (int i = 0; i < 3; i++)
      compare($sformatf("d3.lat%0d_r1_final", lat(i)), rd_o[i], 4'h9);

    $display("[TB] reset two cycles into a slow write");
    applyStimulus(1, 1, 1, 2'd3, 4'h7, 4'h2);
    applyStimulus(1, 1, 1, 2'd3, 4'h7, 4'h2);
    doReset();
    compare("d4.lat4_ack_after_reset", 4'(ack[2]), 4'h0);
    compare("d4.lat4_busy_after_reset", 4'(busy[2]), 4'h0);
    idleSweep();
    compare("d4.lat4_r3_cleared", rd_o[2], 4'h0);

    $display("[TB] ena_wr dropped during BUSY");
    applyStimulus(1, 1, 1, 2'd2, 4'hC, 4'h0);
    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 1, 2'd2, 4'h0, 4'h0);
    compare("d5.lat4_r2_committed", rd_o[2], 4'hC);
    idleSweep();

    $display("[TB] randomized request stream");
    for (int t = 0; t < 80; t++) begin
      hi = int'($urandom_range(1, 8));
      lo = int'($urandom_range(1, 3));
      for (int k = 0; k < hi; k++)
        applyStimulus(1, 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
      for (int k = 0; k < lo; k++)
        applyStimulus(0, 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
    end
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 2'd0, 4'h0, 4'h0);
    idleSweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
